// File: rtl/transaction_control_pkg.sv
// rtl/transaction_control_pkg.sv - shared state encoding and datapath process codes
package transaction_control_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_FETCH       = 4'd1,
      ST_LOAD_REG    = 4'd2,
      ST_WAIT_PLAYER = 4'd3,
      ST_LOAD_PLAYER = 4'd4,
      ST_WAIT_AMT    = 4'd5,
      ST_LOAD_AMT    = 4'd6,
      ST_VERIFY_AMT  = 4'd7,
      ST_WAIT_KEY    = 4'd8,
      ST_LOAD_KEY    = 4'd9,
      ST_VERIFY_KEY  = 4'd10,
      ST_COMMIT      = 4'd11,
      ST_WRITEBACK   = 4'd12,
      ST_DONE        = 4'd13,
      ST_FAIL        = 4'd14,
      ST_CLEAR       = 4'd15
   } state_t;

   localparam logic [2:0] PROC_IDLE   = 3'b000;
   localparam logic [2:0] PROC_AMT    = 3'b001;
   localparam logic [2:0] PROC_KEY    = 3'b010;
   localparam logic [2:0] PROC_COMMIT = 3'b011;

   // States whose exit is governed by the cycle counter.
   function automatic logic is_timed(input state_t s);
      return (s == ST_FETCH) || (s == ST_VERIFY_AMT) || (s == ST_VERIFY_KEY);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge pulse generator for synchronised button levels
module edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level;
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/transaction_control.sv
// rtl/transaction_control.sv - control FSM sequencing one ledger transfer through the datapath
module transaction_control
   import transaction_control_pkg::*;
#(
   parameter int unsigned MEM_LATENCY   = 2,
   parameter int unsigned AMOUNT_CYCLES = 4,
   parameter int unsigned KEY_TIMEOUT   = 200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       confirm,
   input  logic       done_step,
   output logic       mem_read,
   output logic       mem_write,
   output logic       load_register,
   output logic       load_player,
   output logic       load_amount,
   output logic       load_key,
   output logic [2:0] process,
   output logic       dp_clear,
   output logic       tx_ok,
   output logic       tx_fail,
   output logic [3:0] state_dbg
);

   localparam logic [7:0] FETCH_LAST = 8'(MEM_LATENCY - 1);
   localparam logic [7:0] AMT_LAST   = 8'(AMOUNT_CYCLES - 1);
   localparam logic [7:0] KEY_LAST   = 8'(KEY_TIMEOUT - 1);

   state_t     state, state_next;
   logic [7:0] count;
   logic       amt_pass;
   logic       conf_edge;

   edge_detect u_confirm_edge (
      .clock (clock),
      .reset (reset),
      .level (confirm),
      .pulse (conf_edge)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                    count <= 8'd0;
      else if (state_next != state) count <= 8'd0;
      else if (is_timed(state))     count <= count + 8'd1;
   end

   // Sticky: any done_step during the amount window counts as a pass.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                   amt_pass <= 1'b0;
      else if (state != ST_VERIFY_AMT)             amt_pass <= 1'b0;
      else if (done_step)                          amt_pass <= 1'b1;
   end

   always_comb begin
      state_next    = state;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      load_register = 1'b0;
      load_player   = 1'b0;
      load_amount   = 1'b0;
      load_key      = 1'b0;
      process       = PROC_IDLE;
      dp_clear      = 1'b0;
      tx_ok         = 1'b0;
      tx_fail       = 1'b0;
      case (state)
         ST_IDLE:        if (conf_edge) state_next = ST_FETCH;
         ST_FETCH: begin
            mem_read = 1'b1;
            if (count == FETCH_LAST) state_next = ST_LOAD_REG;
         end
         ST_LOAD_REG: begin
            load_register = 1'b1;
            state_next    = ST_WAIT_PLAYER;
         end
         ST_WAIT_PLAYER: if (conf_edge) state_next = ST_LOAD_PLAYER;
         ST_LOAD_PLAYER: begin
            load_player = 1'b1;
            state_next  = ST_WAIT_AMT;
         end
         ST_WAIT_AMT:    if (conf_edge) state_next = ST_LOAD_AMT;
         ST_LOAD_AMT: begin
            load_amount = 1'b1;
            state_next  = ST_VERIFY_AMT;
         end
         ST_VERIFY_AMT: begin
            process = PROC_AMT;
            if (count == AMT_LAST)
               state_next = (amt_pass || done_step) ? ST_WAIT_KEY : ST_FAIL;
         end
         ST_WAIT_KEY:    if (conf_edge) state_next = ST_LOAD_KEY;
         ST_LOAD_KEY: begin
            load_key   = 1'b1;
            state_next = ST_VERIFY_KEY;
         end
         ST_VERIFY_KEY: begin
            process = PROC_KEY;
            if (done_step)              state_next = ST_COMMIT;
            else if (count == KEY_LAST) state_next = ST_FAIL;
         end
         ST_COMMIT: begin
            process    = PROC_COMMIT;
            state_next = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            mem_write  = 1'b1;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            tx_ok = 1'b1;
            if (conf_edge) state_next = ST_CLEAR;
         end
         ST_FAIL: begin
            tx_fail = 1'b1;
            if (conf_edge) state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            dp_clear   = 1'b1;
            state_next = ST_IDLE;
         end
         default:        state_next = ST_IDLE;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_transaction_control.sv
// tb/tb_transaction_control.sv - directed scoreboard bench for transaction_control
module tb_transaction_control;
   import transaction_control_pkg::*;

   localparam int EV_LREG  = 10000;
   localparam int EV_LPLY  = 20000;
   localparam int EV_LAMT  = 30000;
   localparam int EV_LKEY  = 40000;
   localparam int EV_MWR   = 50000;
   localparam int EV_CLR   = 60000;
   localparam int EV_OK    = 70000;
   localparam int EV_FAIL  = 80000;

   logic       clock = 1'b0;
   logic       reset;
   logic       confirm;
   logic       done_step;
   logic       mem_read, mem_write, load_register, load_player, load_amount, load_key;
   logic [2:0] process;
   logic       dp_clear, tx_ok, tx_fail;
   logic [3:0] state_dbg;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   wire [11:0] outs = {mem_read, mem_write, load_register, load_player, load_amount,
                       load_key, dp_clear, tx_ok, tx_fail, process};

   transaction_control #(
      .MEM_LATENCY   (2),
      .AMOUNT_CYCLES (4),
      .KEY_TIMEOUT   (200)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .confirm       (confirm),
      .done_step     (done_step),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .load_register (load_register),
      .load_player   (load_player),
      .load_amount   (load_amount),
      .load_key      (load_key),
      .process       (process),
      .dp_clear      (dp_clear),
      .tx_ok         (tx_ok),
      .tx_fail       (tx_fail),
      .state_dbg     (state_dbg)
   );

   always #5 clock = ~clock;

   function automatic int ev_run(input int code, input int len);
      return 90000 + code * 1000 + len;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic observe(input int ev);
      int e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", ev, 0);
      end else begin
         e = exp_q.pop_front();
         chk("event", ev, e);
      end
   endtask

   // Output monitor: turns strobes and process runs into events for the scoreboard.
   logic [2:0] prev_proc = 3'b000;
   int         run_len   = 0;
   logic       prev_ok   = 1'b0;
   logic       prev_fail = 1'b0;

   always @(negedge clock) begin
      if (process != prev_proc && prev_proc != 3'b000) observe(ev_run(int'(prev_proc), run_len));
      if (process != 3'b000) run_len = (process == prev_proc) ? run_len + 1 : 1;
      prev_proc = process;
      if (load_register) observe(EV_LREG);
      if (load_player)   observe(EV_LPLY);
      if (load_amount)   observe(EV_LAMT);
      if (load_key)      observe(EV_LKEY);
      if (mem_write)     observe(EV_MWR);
      if (dp_clear)      observe(EV_CLR);
      if (tx_ok && !prev_ok)     observe(EV_OK);
      if (tx_fail && !prev_fail) observe(EV_FAIL);
      prev_ok   = tx_ok;
      prev_fail = tx_fail;
   end

   task automatic wait_state(input state_t s, input string tag);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (state_dbg != s && n < 1000);
      chk(tag, int'(state_dbg), int'(s));
   endtask

   task automatic press();
      confirm = 1'b1;
      @(negedge clock);
      confirm = 1'b0;
   endtask

   // From IDLE through amount pass to the start of VERIFY_KEY.
   task automatic front_to_key();
      int cyc;
      exp_q.push_back(EV_LREG);
      exp_q.push_back(EV_LPLY);
      exp_q.push_back(EV_LAMT);
      exp_q.push_back(ev_run(1, 4));
      exp_q.push_back(EV_LKEY);
      press();
      cyc = 1;
      while (!load_register && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      chk("load_register_latency", cyc, 3);
      wait_state(ST_WAIT_PLAYER, "reach_wait_player");
      press();
      wait_state(ST_WAIT_AMT, "reach_wait_amt");
      press();
      wait_state(ST_VERIFY_AMT, "reach_verify_amt");
      @(negedge clock);
      done_step = 1'b1;
      @(negedge clock);
      done_step = 1'b0;
      wait_state(ST_WAIT_KEY, "reach_wait_key");
      press();
      wait_state(ST_VERIFY_KEY, "reach_verify_key");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      confirm   = 1'b0;
      done_step = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_outputs", int'(outs), 0);
      chk("reset_state", int'(state_dbg), 0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_after_reset", int'(state_dbg), int'(ST_IDLE));

      // Happy path: key accepted 37 cycles into VERIFY_KEY
      front_to_key();
      exp_q.push_back(ev_run(2, 38));
      exp_q.push_back(ev_run(3, 1));
      exp_q.push_back(EV_MWR);
      exp_q.push_back(EV_OK);
      repeat (37) @(negedge clock);
      done_step = 1'b1;
      @(negedge clock);
      done_step = 1'b0;
      chk("happy_commit", int'(state_dbg), int'(ST_COMMIT));
      wait_state(ST_DONE, "happy_done");
      chk("happy_tx_ok", int'(tx_ok), 1);
      exp_q.push_back(EV_CLR);
      press();
      wait_state(ST_IDLE, "happy_back_idle");
      chk("happy_queue_empty", exp_q.size(), 0);

      // Button hold and ignored FETCH edge, then amount failure
      exp_q.push_back(EV_LREG);
      exp_q.push_back(EV_LPLY);
      confirm = 1'b1;
      @(negedge clock);
      confirm = 1'b0;
      @(negedge clock);
      chk("hold_in_fetch", int'(state_dbg), int'(ST_FETCH));
      confirm = 1'b1;
      @(negedge clock);
      confirm = 1'b0;
      repeat (3) @(negedge clock);
      chk("fetch_edge_ignored", int'(state_dbg), int'(ST_WAIT_PLAYER));
      confirm = 1'b1;
      repeat (50) @(negedge clock);
      chk("hold_single_player", int'(state_dbg), int'(ST_WAIT_AMT));
      confirm = 1'b0;
      @(negedge clock);
      chk("hold_release_wait_amt", int'(state_dbg), int'(ST_WAIT_AMT));
      exp_q.push_back(EV_LAMT);
      exp_q.push_back(ev_run(1, 4));
      exp_q.push_back(EV_FAIL);
      press();
      wait_state(ST_VERIFY_AMT, "amtfail_verify");
      repeat (4) @(negedge clock);
      chk("amtfail_state_cycle5", int'(state_dbg), int'(ST_FAIL));
      chk("amtfail_tx_fail", int'(tx_fail), 1);
      exp_q.push_back(EV_CLR);
      press();
      wait_state(ST_IDLE, "amtfail_back_idle");
      chk("amtfail_queue_empty", exp_q.size(), 0);

      // Key timeout: 200 cycles at 010 then FAIL
      front_to_key();
      exp_q.push_back(ev_run(2, 200));
      exp_q.push_back(EV_FAIL);
      repeat (200) @(negedge clock);
      chk("timeout_fail", int'(state_dbg), int'(ST_FAIL));
      chk("timeout_tx_fail", int'(tx_fail), 1);
      exp_q.push_back(EV_CLR);
      press();
      wait_state(ST_IDLE, "timeout_back_idle");
      chk("timeout_queue_empty", exp_q.size(), 0);

      // done_step on the timeout cycle wins
      front_to_key();
      exp_q.push_back(ev_run(2, 200));
      exp_q.push_back(ev_run(3, 1));
      exp_q.push_back(EV_MWR);
      exp_q.push_back(EV_OK);
      repeat (199) @(negedge clock);
      done_step = 1'b1;
      @(negedge clock);
      done_step = 1'b0;
      chk("last_cycle_commit", int'(state_dbg), int'(ST_COMMIT));
      wait_state(ST_DONE, "last_cycle_done");
      exp_q.push_back(EV_CLR);
      press();
      wait_state(ST_IDLE, "last_cycle_back_idle");
      chk("last_cycle_queue_empty", exp_q.size(), 0);

      // Asynchronous reset in the middle of VERIFY_KEY
      front_to_key();
      exp_q.push_back(ev_run(2, 5));
      repeat (4) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_outputs", int'(outs), 0);
      chk("async_reset_state", int'(state_dbg), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      chk("post_reset_idle", int'(state_dbg), int'(ST_IDLE));
      chk("post_reset_queue_empty", exp_q.size(), 0);

      // Recovery: a fresh transaction after reset
      front_to_key();
      exp_q.push_back(ev_run(2, 1));
      exp_q.push_back(ev_run(3, 1));
      exp_q.push_back(EV_MWR);
      exp_q.push_back(EV_OK);
      done_step = 1'b1;
      @(negedge clock);
      done_step = 1'b0;
      wait_state(ST_DONE, "recovery_done");
      chk("recovery_tx_ok", int'(tx_ok), 1);
      exp_q.push_back(EV_CLR);
      press();
      wait_state(ST_IDLE, "recovery_back_idle");
      repeat (3) @(negedge clock);
      chk("recovery_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
